// File: rtl/irq_request_latch.sv
// Request synchronizer, sticky pending latch and valid/ack presenter.
// Optional IRQ_OVERRUN_CNT_EN adds a saturating overrun_cnt output.
module irq_request_latch #(
  parameter int N      = 8,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_in,
  input  logic [N-1:0]      mask,
  input  logic              irq_ack,
  output logic              irq_valid,
  output logic [CODE_W-1:0] irq_code,
  output logic [N-1:0]      pending
`ifdef IRQ_OVERRUN_CNT_EN
  ,
  output logic [7:0]        overrun_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    CLEAR
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0] s1_q, s2_q, s3_q;
  logic [N-1:0] s1_d, s2_d, s3_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] rise, elig, clr;

  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] srv_q, srv_d;
  logic [CODE_W-1:0] hi;

  always_comb begin
    s1_d = req_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_comb begin
    rise = s2_q & ~s3_q;
    elig = pend_q & ~mask;
    hi   = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) hi = CODE_W'(i);
    end
  end

  // A fresh edge landing in the CLEAR cycle must survive the clear.
  always_comb begin
    clr = '0;
    if (state_q == CLEAR) clr[srv_q] = 1'b1;
    pend_d = (pend_q & ~clr) | rise;
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    srv_d   = srv_q;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = PRESENT;
          valid_d = 1'b1;
          code_d  = hi;
          srv_d   = hi;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          state_d = CLEAR;
          valid_d = 1'b0;
          code_d  = '0;
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        code_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      pend_q  <= '0;
      state_q <= IDLE;
      valid_q <= 1'b0;
      code_q  <= '0;
      srv_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      srv_q   <= srv_d;
    end
  end

  assign irq_valid = valid_q;
  assign irq_code  = code_q;
  assign pending   = pend_q;

`ifdef IRQ_OVERRUN_CNT_EN
  logic [7:0] ovr_q, ovr_d;
  logic       ovr_hit;

  always_comb begin
    ovr_hit = |(rise & pend_q & ~clr);
    ovr_d   = ovr_q;
    if (ovr_hit && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovr_q <= '0;
    else     ovr_q <= ovr_d;
  end

  assign overrun_cnt = ovr_q;
`endif

endmodule
